// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arb_pkg
// Purpose  : Shared types and constants for the 8-way round-robin arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package arb_pkg;

  localparam int NUM_REQ = 8;
  localparam int ID_W    = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Result of the rotating priority scan.
  typedef struct packed {
    logic            any_req;
    logic [ID_W-1:0] winner;
  } scan_t;

endpackage
`default_nettype wire

// File: rtl/onehot_dec3to8.sv
`default_nettype none
// ============================================================================
// Module   : onehot_dec3to8
// Purpose  : Combinational 3-to-8 one-hot decoder.
// Revision : 1.0 - initial release
// ============================================================================
module onehot_dec3to8
  import arb_pkg::*;
(
  input  logic [ID_W-1:0]    sel,
  output logic [NUM_REQ-1:0] onehot
);

  // One output bit per select value.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_dec
    assign onehot[i] = (sel == ID_W'(i));
  end

endmodule
`default_nettype wire

// File: rtl/rr_onehot_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_onehot_arbiter
// Purpose  : 8-way round-robin arbiter with registered one-hot grant and
//            binary grant index. The grant is held until its owner drops req.
//            Optional macro ARB_TIMEOUT_EN adds a forced release after
//            MAX_HOLD consecutive grant cycles (parameters exist only then).
// Revision : 1.0 - initial release
// ============================================================================
module rr_onehot_arbiter
  import arb_pkg::*;
`ifdef ARB_TIMEOUT_EN
#(
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 5
)
`endif
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               gnt_vld,
  output logic               timeout_o
);

  // Rotating scan: lowest offset from ptr wins, so iterate from the far end
  // and let nearer hits overwrite farther ones.
  function automatic scan_t rr_scan(input logic [NUM_REQ-1:0] r,
                                    input logic [ID_W-1:0]    p);
    scan_t           s;
    logic [ID_W-1:0] idx;
    s = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = p + ID_W'(i);
      if (r[idx]) begin
        s.any_req = 1'b1;
        s.winner  = idx;
      end
    end
    return s;
  endfunction

  arb_state_t         r_state;
  arb_state_t         w_state_nxt;
  logic [ID_W-1:0]    r_ptr;
  logic [ID_W-1:0]    w_ptr_nxt;
  logic [NUM_REQ-1:0] r_gnt;
  logic [ID_W-1:0]    r_gnt_id;
  logic [NUM_REQ-1:0] w_dec;
  logic               w_load;
  logic               w_clear;
  scan_t              w_scan;
`ifdef ARB_TIMEOUT_EN
  logic [HOLD_W-1:0]  r_hold_cnt;
  logic               r_timeout;
  logic               w_timeout_nxt;
`endif

  assign w_scan = rr_scan(req, r_ptr);

  onehot_dec3to8 u_dec (
    .sel    (w_scan.winner),
    .onehot (w_dec)
  );

  // Next-state and grant load/clear decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_load      = 1'b0;
    w_clear     = 1'b0;
`ifdef ARB_TIMEOUT_EN
    w_timeout_nxt = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (w_scan.any_req) begin
          w_state_nxt = GRANT;
          w_load      = 1'b1;
          w_ptr_nxt   = w_scan.winner + ID_W'(1);
        end
      end
      GRANT: begin
        if (!req[r_gnt_id]) begin
          w_state_nxt = IDLE;
          w_clear     = 1'b1;
        end
`ifdef ARB_TIMEOUT_EN
        else if (r_hold_cnt == HOLD_W'(MAX_HOLD - 1)) begin
          w_state_nxt   = IDLE;
          w_clear       = 1'b1;
          w_timeout_nxt = 1'b1;
        end
`endif
      end
      default: begin
        w_state_nxt = IDLE;
        w_clear     = 1'b1;
      end
    endcase
  end

  // State, pointer and registered grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_ptr    <= '0;
      r_gnt    <= '0;
      r_gnt_id <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      if (w_load) begin
        r_gnt    <= w_dec;
        r_gnt_id <= w_scan.winner;
      end else if (w_clear) begin
        r_gnt    <= '0;
        r_gnt_id <= '0;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Hold counter restarts on each new grant and counts grant cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_timeout <= w_timeout_nxt;
      if (w_load) begin
        r_hold_cnt <= '0;
      end else if (r_state == GRANT) begin
        r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
      end
    end
  end

  assign timeout_o = r_timeout;
`else
  assign timeout_o = 1'b0;
`endif

  assign gnt     = r_gnt;
  assign gnt_id  = r_gnt_id;
  assign gnt_vld = |r_gnt;

  // The grant must never carry more than one bit.
  a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));

endmodule
`default_nettype wire

// File: tb/tb_rr_onehot_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_onehot_arbiter
// Purpose  : Self-checking bench for rr_onehot_arbiter: directed scenarios
//            plus randomized requests against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_onehot_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = 8'h00;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_vld;
  logic       timeout_o;

  int total = 0;
  int bad   = 0;

  // Behavioural model: owner index (-1 = none), rotating pointer, hold count.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_hold  = 0;
  bit m_to    = 1'b0;
  localparam int MAXH = 16;

  rr_onehot_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_vld   (gnt_vld),
    .timeout_o (timeout_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_hold  = 0;
    m_to    = 1'b0;
  endtask

  // Advance the model by one clock edge with request vector r.
  task automatic model_step(input logic [7:0] r);
    int c;
    m_to = 1'b0;
    if (m_owner < 0) begin
      for (int i = 0; i < 8; i++) begin
        c = (m_ptr + i) % 8;
        if (r[c] && m_owner < 0) begin
          m_owner = c;
          m_ptr   = (c + 1) % 8;
          m_hold  = 0;
        end
      end
    end else if (!r[m_owner]) begin
      m_owner = -1;
    end else begin
`ifdef ARB_TIMEOUT_EN
      if (m_hold == MAXH - 1) begin
        m_owner = -1;
        m_to    = 1'b1;
      end else begin
        m_hold++;
      end
`else
      m_hold++;
`endif
    end
  endtask

  task automatic model_check();
    logic [7:0] eg;
    eg = (m_owner < 0) ? 8'h00 : (8'h01 << m_owner);
    chk("gnt",     {24'd0, gnt},     {24'd0, eg});
    chk("gnt_id",  {29'd0, gnt_id},  (m_owner < 0) ? 32'd0 : m_owner);
    chk("gnt_vld", {31'd0, gnt_vld}, (m_owner < 0) ? 32'd0 : 32'd1);
    chk("timeout", {31'd0, timeout_o}, {31'd0, m_to});
  endtask

  // Called just after a falling edge: apply r, let one rising edge pass, check.
  task automatic cycle(input logic [7:0] r);
    req = r;
    model_step(r);
    @(negedge clk);
    model_check();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = 8'hFF;
    repeat (2) @(negedge clk);
    chk("rst_gnt",     {24'd0, gnt},       32'd0);
    chk("rst_gnt_id",  {29'd0, gnt_id},    32'd0);
    chk("rst_gnt_vld", {31'd0, gnt_vld},   32'd0);
    chk("rst_timeout", {31'd0, timeout_o}, 32'd0);
    model_reset();
    rst_n = 1'b1;
    req   = 8'h00;
  endtask

  initial begin
    logic [7:0] r;

    // 1. Reset with all requests high
    do_reset();

    // 2. Single requester
    cycle(8'h20);
    chk("t2_gnt", {24'd0, gnt}, 32'h20);
    chk("t2_id",  {29'd0, gnt_id}, 32'd5);
    cycle(8'h20);
    chk("t2_hold", {24'd0, gnt}, 32'h20);
    cycle(8'h00);
    chk("t2_rel", {24'd0, gnt}, 32'h00);

    // 3. Rotation with all requesting, each owner drops for one cycle
    do_reset();
    for (int k = 0; k < 9; k++) begin
      cycle(8'hFF);
      chk("t3_gnt", {24'd0, gnt}, 32'h1 << (k % 8));
      cycle(8'hFF & ~(8'h01 << (k % 8)));
      chk("t3_idle", {24'd0, gnt}, 32'h0);
    end

    // 4. Wrap: owner 7 with 0 pending -> 0 then 7
    do_reset();
    cycle(8'h80);
    chk("t4_g7", {24'd0, gnt}, 32'h80);
    cycle(8'h81);
    chk("t4_hold7", {24'd0, gnt}, 32'h80);
    cycle(8'h01);
    chk("t4_idle", {24'd0, gnt}, 32'h00);
    cycle(8'h81);
    chk("t4_g0", {24'd0, gnt}, 32'h01);
    cycle(8'h80);
    cycle(8'h81);
    chk("t4_g7b", {24'd0, gnt}, 32'h80);

    // 5. Async reset mid-grant
    do_reset();
    cycle(8'h01);
    cycle(8'h00);
    cycle(8'h08);
    chk("t5_g3", {24'd0, gnt}, 32'h08);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_gnt", {24'd0, gnt}, 32'h00);
    chk("t5_async_vld", {31'd0, gnt_vld}, 32'd0);
    model_reset();
    req = 8'h0C;
    model_step(8'h0C);
    #1 rst_n = 1'b1;
    @(negedge clk);
    model_check();
    chk("t5_g2", {24'd0, gnt}, 32'h04);
    chk("t5_id", {29'd0, gnt_id}, 32'd2);

`ifdef ARB_TIMEOUT_EN
    // 6. Forced release after MAX_HOLD cycles
    do_reset();
    for (int k = 0; k < MAXH; k++) begin
      cycle(8'h0C);
      chk("t6_hold", {24'd0, gnt}, 32'h04);
    end
    cycle(8'h0C);
    chk("t6_rel", {24'd0, gnt}, 32'h00);
    chk("t6_to",  {31'd0, timeout_o}, 32'd1);
    cycle(8'h0C);
    chk("t6_next", {24'd0, gnt}, 32'h08);
    chk("t6_to0",  {31'd0, timeout_o}, 32'd0);
`endif

    // Randomized requests against the model
    do_reset();
    r = 8'h00;
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 7))
        0:       r = 8'($urandom);
        1, 2:    r = r ^ (8'h01 << $urandom_range(0, 7));
        3:       r = 8'h00;
        default: r = r;
      endcase
      cycle(r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case something stalls the stimulus.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
